// File: rtl/sparc_win_regfile.sv
// SPARC-style windowed register file: 8 globals plus NWINDOWS overlapping
// 16-register windows, two registered read ports, one write port, and
// CWP management for SAVE/RESTORE with WIM overflow/underflow detection.
module sparc_win_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NWINDOWS = 8,
  parameter int unsigned CWP_W    = $clog2(NWINDOWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              save,
  input  logic              restore,
  input  logic              cwp_ld,
  input  logic [CWP_W-1:0]  cwp_ld_val,
  input  logic [NWINDOWS-1:0] wim,
  output logic [CWP_W-1:0]  cwp,
  output logic              wovf,
  output logic              wunf,
  output logic              win_err
);

  localparam int unsigned DEPTH = 8 + 16 * NWINDOWS;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [CWP_W-1:0]  cwp_q, cwp_d;
  logic              wovf_q, wovf_d;
  logic              wunf_q, wunf_d;
  logic              win_err_q, win_err_d;
  logic [DATA_W-1:0] rs1_q, rs1_d;
  logic [DATA_W-1:0] rs2_q, rs2_d;

  logic [AW-1:0]     wa, ra1, ra2;
  logic              wr_live;
  logic [CWP_W-1:0]  n_save, n_restore;

  // Logical-to-physical mapping. Windowed registers wrap modulo the window
  // ring so the ins of window w land on the outs of window w+1.
  function automatic logic [AW-1:0] map_reg(input logic [4:0] r, input logic [CWP_W-1:0] c);
    int unsigned off;
    int unsigned idx;
    if (r < 5'd8) begin
      idx = 32'(r);
    end else begin
      off = 32'(c) * 16 + 32'(r) - 32'd8;
      idx = 8 + (off % (NWINDOWS * 16));
    end
    return AW'(idx);
  endfunction

  // Address mapping always uses the pre-edge window pointer.
  always_comb begin
    wa      = map_reg(wr_addr, cwp_q);
    ra1     = map_reg(rs1_addr, cwp_q);
    ra2     = map_reg(rs2_addr, cwp_q);
    wr_live = wr_en && (wr_addr != 5'd0);
  end

  // Read data next-state: r0 is hard zero, same-edge writes bypass the array.
  always_comb begin
    rs1_d = '0;
    rs2_d = '0;
    if (rs1_addr != 5'd0) begin
      rs1_d = (wr_live && (wa == ra1)) ? wr_data : mem_q[ra1];
    end
    if (rs2_addr != 5'd0) begin
      rs2_d = (wr_live && (wa == ra2)) ? wr_data : mem_q[ra2];
    end
  end

  // Window control: cwp_ld > save&restore > save > restore.
  always_comb begin
    cwp_d     = cwp_q;
    wovf_d    = 1'b0;
    wunf_d    = 1'b0;
    win_err_d = 1'b0;
    n_save    = (cwp_q == '0) ? CWP_W'(NWINDOWS - 1) : cwp_q - CWP_W'(1);
    n_restore = (cwp_q == CWP_W'(NWINDOWS - 1)) ? '0 : cwp_q + CWP_W'(1);
    if (cwp_ld) begin
      cwp_d = cwp_ld_val;
    end else if (save && restore) begin
      win_err_d = 1'b1;
    end else if (save) begin
      if (wim[n_save]) wovf_d = 1'b1;
      else             cwp_d  = n_save;
    end else if (restore) begin
      if (wim[n_restore]) wunf_d = 1'b1;
      else                cwp_d  = n_restore;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cwp_q     <= '0;
      wovf_q    <= 1'b0;
      wunf_q    <= 1'b0;
      win_err_q <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else begin
      cwp_q     <= cwp_d;
      wovf_q    <= wovf_d;
      wunf_q    <= wunf_d;
      win_err_q <= win_err_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
    end
  end

  // Storage array; not reset, but writes are suppressed while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_live) begin
      mem_q[wa] <= wr_data;
    end
  end

  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;
  assign cwp      = cwp_q;
  assign wovf     = wovf_q;
  assign wunf     = wunf_q;
  assign win_err  = win_err_q;

endmodule

// File: tb/tb_sparc_win_regfile.sv
// Scoreboard bench for sparc_win_regfile: expected outputs are queued as
// stimulus is driven and compared one edge later.
module tb_sparc_win_regfile;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NWINDOWS = 8;
  localparam int unsigned CWP_W    = 3;

  localparam int unsigned S_RS1  = 0;
  localparam int unsigned S_RS2  = 1;
  localparam int unsigned S_CWP  = 2;
  localparam int unsigned S_WOVF = 3;
  localparam int unsigned S_WUNF = 4;
  localparam int unsigned S_WERR = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [4:0]        rs1_addr, rs2_addr;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic              save, restore, cwp_ld;
  logic [CWP_W-1:0]  cwp_ld_val;
  logic [NWINDOWS-1:0] wim;
  logic [CWP_W-1:0]  cwp;
  logic              wovf, wunf, win_err;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  sparc_win_regfile #(
    .DATA_W   (DATA_W),
    .NWINDOWS (NWINDOWS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .save       (save),
    .restore    (restore),
    .cwp_ld     (cwp_ld),
    .cwp_ld_val (cwp_ld_val),
    .wim        (wim),
    .cwp        (cwp),
    .wovf       (wovf),
    .wunf       (wunf),
    .win_err    (win_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int unsigned sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  // Advance one edge, then drain every expectation queued for it.
  task automatic step();
    exp_t e;
    logic [31:0] got;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        S_RS1:   got = rs1_data;
        S_RS2:   got = rs2_data;
        S_CWP:   got = 32'(cwp);
        S_WOVF:  got = 32'(wovf);
        S_WUNF:  got = 32'(wunf);
        default: got = 32'(win_err);
      endcase
      check(e.tag, got, e.val);
    end
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    save    = 1'b0;
    restore = 1'b0;
    cwp_ld  = 1'b0;
  endtask

  task automatic push_pulses(input string tag, input logic ov, input logic un, input logic er);
    sb_push({tag, "_wovf"}, S_WOVF, 32'(ov));
    sb_push({tag, "_wunf"}, S_WUNF, 32'(un));
    sb_push({tag, "_werr"}, S_WERR, 32'(er));
  endtask

  initial begin
    rst_n = 1'b0; idle();
    wr_addr = '0; wr_data = '0; rs1_addr = '0; rs2_addr = '0;
    cwp_ld_val = '0; wim = '0;

    // Reset state
    save = 1'b1;
    rs1_addr = 5'd3; rs2_addr = 5'd4;
    sb_push("rst_cwp", S_CWP, 0);
    sb_push("rst_rs1", S_RS1, 0);
    sb_push("rst_rs2", S_RS2, 0);
    push_pulses("rst", 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1; idle();
    rs1_addr = '0; rs2_addr = '0;
    step();

    // 1: write r1, read back with one-cycle latency
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hDEADBEEF;
    step();
    wr_en = 1'b0; rs1_addr = 5'd1;
    sb_push("r1_read", S_RS1, 32'hDEADBEEF);
    step();

    // 2: r0 is hard zero even with a same-edge write; bypass on r9
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rs1_addr = 5'd0;
    sb_push("r0_wr_bypass", S_RS1, 0);
    step();
    wr_en = 1'b0;
    sb_push("r0_read", S_RS1, 0);
    step();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5; rs2_addr = 5'd9; rs1_addr = 5'd1;
    sb_push("r9_bypass", S_RS2, 32'hA5A5A5A5);
    sb_push("r1_port1", S_RS1, 32'hDEADBEEF);
    step();
    wr_en = 1'b0;
    sb_push("r9_stored", S_RS2, 32'hA5A5A5A5);
    step();

    // 3: window overlap through save/restore
    cwp_ld = 1'b1; cwp_ld_val = 3'd3;
    sb_push("ld3_cwp", S_CWP, 3);
    step();
    idle();
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h11;
    step();
    wr_en = 1'b0; save = 1'b1;
    sb_push("save32_cwp", S_CWP, 2);
    push_pulses("save32", 1'b0, 1'b0, 1'b0);
    step();
    idle(); rs1_addr = 5'd24;
    sb_push("w2_r24", S_RS1, 32'h11);
    step();
    restore = 1'b1;
    sb_push("rest23_cwp", S_CWP, 3);
    step();
    idle(); rs1_addr = 5'd8;
    sb_push("w3_r8", S_RS1, 32'h11);
    step();
    // Write and save in the same cycle: write lands in window 3's r10,
    // which window 2 sees as r26.
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h22; save = 1'b1;
    sb_push("wsave_cwp", S_CWP, 2);
    step();
    idle(); rs1_addr = 5'd26; rs2_addr = 5'd10;
    sb_push("w2_r26", S_RS1, 32'h22);
    sb_push("w2_r10_other", S_RS2, 32'h0 | 32'h0);
    sb_q.pop_back();
    step();

    // 4: wrap both ways
    cwp_ld = 1'b1; cwp_ld_val = 3'd0;
    sb_push("ld0_cwp", S_CWP, 0);
    step();
    idle(); save = 1'b1;
    sb_push("wrap_save_cwp", S_CWP, 7);
    step();
    idle(); restore = 1'b1;
    sb_push("wrap_rest_cwp", S_CWP, 0);
    step();

    // 5: overflow/underflow against WIM
    idle(); cwp_ld = 1'b1; cwp_ld_val = 3'd4;
    sb_push("ld4_cwp", S_CWP, 4);
    step();
    idle(); wim = 8'b0000_1000; save = 1'b1;
    sb_push("ovf_cwp", S_CWP, 4);
    push_pulses("ovf", 1'b1, 1'b0, 1'b0);
    step();
    idle();
    push_pulses("ovf_clr", 1'b0, 1'b0, 1'b0);
    step();
    wim = 8'b0010_0000; restore = 1'b1;
    sb_push("unf_cwp", S_CWP, 4);
    push_pulses("unf", 1'b0, 1'b1, 1'b0);
    step();
    idle();
    push_pulses("unf_clr", 1'b0, 1'b0, 1'b0);
    step();

    // 6: conflict, load priority, reset mid-operation
    wim = '0; save = 1'b1; restore = 1'b1;
    sb_push("err_cwp", S_CWP, 4);
    push_pulses("err", 1'b0, 1'b0, 1'b1);
    step();
    idle();
    push_pulses("err_clr", 1'b0, 1'b0, 1'b0);
    step();
    wim = 8'b0010_0000; cwp_ld = 1'b1; cwp_ld_val = 3'd6; save = 1'b1;
    sb_push("ldsave_cwp", S_CWP, 6);
    push_pulses("ldsave", 1'b0, 1'b0, 1'b0);
    step();
    idle(); wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hCAFE0002;
    step();
    // Save would hit wim[5] and the write would overwrite r2; reset drops both.
    idle(); rst_n = 1'b0; save = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hBAD00002; rs1_addr = 5'd2;
    sb_push("rst2_cwp", S_CWP, 0);
    sb_push("rst2_rs1", S_RS1, 0);
    push_pulses("rst2", 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1; idle(); rs1_addr = 5'd2;
    sb_push("rst2_r2_kept", S_RS1, 32'hCAFE0002);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
